// File: rtl/half_matvec_ctrl.sv
// Sequencer ahead of half_dot_v_v: loads x and ROWS weight rows from one stream,
// runs one dot product per row and streams out the (optionally ReLU-clamped) results.
module half_matvec_ctrl #(
    parameter int WIDTH = 10,
    parameter int ROWS  = 4,
    parameter int RELU  = 1,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int EW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  go,
    output logic                  busy,
    output logic                  all_done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_data,
    output logic [RW-1:0]         out_row,
    output logic                  dot_start,
    output logic [16*WIDTH-1:0]   dot_vector_a,
    output logic [16*WIDTH-1:0]   dot_vector_b,
    input  logic                  dot_done,
    input  logic [15:0]           dot_c
);

    // state    | meaning
    // IDLE     | waiting for go
    // LOAD_X   | accepting the WIDTH words of x
    // LOAD_W   | accepting the WIDTH words of the current weight row
    // FIRE     | dot_start high for one cycle
    // SETTLE   | one cycle so a dot_done left over from the previous row is ignored
    // WAIT     | waiting for dot_done, then capture dot_c
    // OUT      | result presented until out_ready
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_X,
        ST_LOAD_W,
        ST_FIRE,
        ST_SETTLE,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t          state;
    logic [EW-1:0]   elem;
    logic [RW-1:0]   row;
    logic [15:0]     x_reg [WIDTH];
    logic [15:0]     w_reg [WIDTH];

    logic            in_fire;
    logic            last_elem;
    logic            last_row;
    logic [15:0]     relu_c;

    assign in_fire   = in_valid && in_ready;
    assign last_elem = (elem == EW'(WIDTH - 1));
    assign last_row  = (row == RW'(ROWS - 1));
    // Sign bit set covers -0, negatives, -inf and sign-set NaN alike.
    assign relu_c    = ((RELU != 0) && dot_c[15]) ? 16'h0000 : dot_c;

    for (genvar g = 0; g < WIDTH; g++) begin : g_vec
        assign dot_vector_a[16*g +: 16] = x_reg[g];
        assign dot_vector_b[16*g +: 16] = w_reg[g];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            all_done  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_row   <= '0;
            dot_start <= 1'b0;
            elem      <= '0;
            row       <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                x_reg[i] <= 16'h0000;
                w_reg[i] <= 16'h0000;
            end
        end else begin
            all_done  <= 1'b0;
            dot_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (go) begin
                        state    <= ST_LOAD_X;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        elem     <= '0;
                        row      <= '0;
                    end
                end
                ST_LOAD_X: begin
                    if (in_fire) begin
                        x_reg[elem] <= in_data;
                        if (last_elem) begin
                            elem  <= '0;
                            state <= ST_LOAD_W;
                        end else begin
                            elem <= elem + 1'b1;
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (in_fire) begin
                        w_reg[elem] <= in_data;
                        if (last_elem) begin
                            elem      <= '0;
                            in_ready  <= 1'b0;
                            dot_start <= 1'b1;
                            state     <= ST_FIRE;
                        end else begin
                            elem <= elem + 1'b1;
                        end
                    end
                end
                ST_FIRE: begin
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dot_done) begin
                        out_data  <= relu_c;
                        out_row   <= row;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_row) begin
                            all_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            row      <= row + 1'b1;
                            in_ready <= 1'b1;
                            state    <= ST_LOAD_W;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_matvec_ctrl.sv
// Bench for half_matvec_ctrl: a ReLU and a pass-through instance share one stream
// and one behavioural dot stage; results are checked against queued expectations.
module tb_half_matvec_ctrl;

    localparam int WIDTH = 4;
    localparam int ROWS  = 2;
    localparam int RW    = 1;
    localparam int TOT   = WIDTH * (ROWS + 1);

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 go = 1'b0;
    logic                 in_valid = 1'b0;
    logic [15:0]          in_data = 16'h0000;
    logic                 out_ready = 1'b0;
    logic                 dot_done = 1'b0;
    logic [15:0]          dot_c = 16'h0000;

    logic                 r_busy, r_all_done, r_in_ready, r_out_valid, r_dot_start;
    logic [15:0]          r_out_data;
    logic [RW-1:0]        r_out_row;
    logic [16*WIDTH-1:0]  r_vec_a, r_vec_b;
    logic                 p_busy, p_all_done, p_in_ready, p_out_valid, p_dot_start;
    logic [15:0]          p_out_data;
    logic [RW-1:0]        p_out_row;
    logic [16*WIDTH-1:0]  p_vec_a, p_vec_b;

    half_matvec_ctrl #(.WIDTH(WIDTH), .ROWS(ROWS), .RELU(1)) u_relu (
        .clk(clk), .rstn(rstn), .go(go), .busy(r_busy), .all_done(r_all_done),
        .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
        .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
        .out_row(r_out_row), .dot_start(r_dot_start), .dot_vector_a(r_vec_a),
        .dot_vector_b(r_vec_b), .dot_done(dot_done), .dot_c(dot_c)
    );

    half_matvec_ctrl #(.WIDTH(WIDTH), .ROWS(ROWS), .RELU(0)) u_pass (
        .clk(clk), .rstn(rstn), .go(go), .busy(p_busy), .all_done(p_all_done),
        .in_valid(in_valid), .in_ready(p_in_ready), .in_data(in_data),
        .out_valid(p_out_valid), .out_ready(out_ready), .out_data(p_out_data),
        .out_row(p_out_row), .dot_start(p_dot_start), .dot_vector_a(p_vec_a),
        .dot_vector_b(p_vec_b), .dot_done(dot_done), .dot_c(dot_c)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_relu(input logic [15:0] v);
        return v[15] ? 16'h0000 : v;
    endfunction

    function automatic logic [15:0] rand_half();
        case ($urandom_range(0, 6))
            0:       return 16'h8000;
            1:       return 16'hFC00;
            2:       return 16'hFE01;
            3:       return 16'h7C00;
            default: return 16'($urandom());
        endcase
    endfunction

    // stimulus / expectation queues
    logic [15:0] in_q[$];
    logic [63:0] x_q[$];
    logic [63:0] w_q[$];
    logic [15:0] res_q[$];
    logic [15:0] exp_res_q[$];
    int          exp_row_q[$];

    bit rand_in = 0, rand_out = 0, stall_out = 0, stale = 0, long_lat = 0;

    // monitor-owned state
    bit          in_hs = 0, exp_start = 0, exp_done = 0, stall_prev = 0, st_seen = 0;
    int          wcnt = 0, rcnt = 0, ov_wait = 0, done_cnt = 0;
    logic [63:0] x_cur = '0;
    logic [15:0] pend = '0, prev_data = '0;
    logic [RW-1:0] prev_row = '0;

    // behavioural dot stage state
    int          age = 0, lat_cur = 2;
    bit          stale_cur = 0;
    logic [15:0] dot_pend = '0;

    task automatic push_op(input bit directed);
        logic [63:0] xv, wv;
        xv = directed ? {4{16'h3C00}} : {$urandom(), $urandom()};
        for (int i = 0; i < WIDTH; i++) in_q.push_back(xv[16*i +: 16]);
        x_q.push_back(xv);
        for (int r = 0; r < ROWS; r++) begin
            if (directed) wv = (r == 0) ? {4{16'h4000}} : {4{16'hBC00}};
            else          wv = {$urandom(), $urandom()};
            for (int i = 0; i < WIDTH; i++) in_q.push_back(wv[16*i +: 16]);
            w_q.push_back(wv);
            if (directed) res_q.push_back((r == 0) ? 16'h4800 : 16'hC400);
            else          res_q.push_back(rand_half());
        end
    endtask

    // input / output stream driver
    always begin
        @(posedge clk);
        #1;
        if (in_hs && in_q.size() > 0) void'(in_q.pop_front());
        if (in_q.size() > 0 && (!rand_in || $urandom_range(0, 1) == 1)) begin
            in_valid = 1'b1;
            in_data  = in_q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = 16'($urandom());
        end
        if (rand_out)       out_ready = 1'($urandom_range(0, 1));
        else if (stall_out) out_ready = (ov_wait >= 10);
        else                out_ready = 1'b1;
    end

    // dot stage: done clears on start (or one cycle later in stale mode), rises after lat_cur
    always @(posedge clk) begin
        if (!rstn) begin
            dot_done <= 1'b0;
            age      <= 0;
        end else if (st_seen) begin
            age       <= 1;
            lat_cur   <= long_lat ? 6 : int'($urandom_range(2, 6));
            dot_pend  <= pend;
            stale_cur <= stale;
            if (!stale) begin
                dot_done <= 1'b0;
                dot_c    <= 16'h5A5A;
            end
        end else if (age != 0) begin
            if (age == 1) begin
                dot_done <= 1'b0;
                dot_c    <= 16'h5A5A;
            end
            if (age == lat_cur) begin
                dot_done <= 1'b1;
                dot_c    <= dot_pend;
                age      <= 0;
            end else begin
                age <= age + 1;
            end
        end
    end

    // monitor and scoreboard
    always @(negedge clk) begin
        if (!rstn) begin
            in_q.delete(); x_q.delete(); w_q.delete(); res_q.delete();
            exp_res_q.delete(); exp_row_q.delete();
            in_hs = 0; exp_start = 0; exp_done = 0; stall_prev = 0; st_seen = 0;
            wcnt = 0; rcnt = 0; ov_wait = 0;
        end else begin
            chk("twin_ctl", {p_busy, p_all_done, p_in_ready, p_out_valid, p_out_row, p_dot_start},
                            {r_busy, r_all_done, r_in_ready, r_out_valid, r_out_row, r_dot_start});
            chk("twin_vec", p_vec_a ^ p_vec_b, r_vec_a ^ r_vec_b);
            chk("dot_start_lat", r_dot_start, exp_start);
            chk("all_done_pos", r_all_done, exp_done);
            chk("in_ready_excl", r_in_ready & (r_out_valid | r_dot_start | ~r_busy), 1'b0);
            if (stall_prev) begin
                chk("stall_valid", r_out_valid, 1'b1);
                chk("stall_hold", {r_out_row, r_out_data}, {prev_row, prev_data});
            end
            exp_start = 0;
            exp_done  = 0;
            st_seen   = r_dot_start;
            if (r_dot_start) begin
                if (w_q.size() == 0 || res_q.size() == 0) begin
                    chk("dot_start_unexp", 1'b1, 1'b0);
                end else begin
                    if (rcnt == 0 && x_q.size() > 0) x_cur = x_q.pop_front();
                    chk("vec_a", r_vec_a, x_cur);
                    chk("vec_b", r_vec_b, w_q.pop_front());
                    pend = res_q.pop_front();
                    exp_res_q.push_back(pend);
                    exp_row_q.push_back(rcnt);
                    rcnt = (rcnt + 1) % ROWS;
                end
            end
            in_hs = in_valid && r_in_ready;
            if (in_hs) begin
                if (wcnt % TOT >= WIDTH && (wcnt % TOT + 1) % WIDTH == 0) exp_start = 1;
                wcnt++;
            end
            if (r_out_valid && out_ready) begin
                if (exp_res_q.size() == 0) begin
                    chk("out_unexp", 1'b1, 1'b0);
                end else begin
                    logic [15:0] r;
                    int row;
                    r   = exp_res_q.pop_front();
                    row = exp_row_q.pop_front();
                    chk("out_relu", r_out_data, ref_relu(r));
                    chk("out_pass", p_out_data, r);
                    chk("out_row", r_out_row, row);
                    chk("busy_out", r_busy, 1'b1);
                    if (row == ROWS - 1) exp_done = 1;
                end
                ov_wait = 0;
            end else if (r_out_valid) begin
                ov_wait++;
            end
            stall_prev = r_out_valid && !out_ready;
            prev_data  = r_out_data;
            prev_row   = r_out_row;
            if (r_all_done) done_cnt++;
        end
    end

    task automatic check_reset_vals();
        chk("rst_ctl", {r_busy, r_all_done, r_in_ready, r_out_valid, r_dot_start, r_out_row}, '0);
        chk("rst_out_data", r_out_data, 16'h0000);
        chk("rst_vec_a", r_vec_a, '0);
        chk("rst_vec_b", r_vec_b, '0);
        chk("rst_pass", {p_busy, p_all_done, p_in_ready, p_out_valid, p_dot_start, p_out_row, p_out_data}, '0);
    endtask

    task automatic pulse_go();
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
    endtask

    task automatic wait_sig(input int which, input int budget);
        int  n;
        bit  hit;
        n = 0;
        hit = 0;
        while (!hit && n < budget) begin
            @(negedge clk);
            case (which)
                0:       hit = r_dot_start;
                1:       hit = r_out_valid;
                default: hit = r_all_done;
            endcase
            n++;
        end
        chk("wait_timeout", hit, 1'b1);
    endtask

    task automatic settle_check(input int d0, input int ops);
        repeat (3) @(negedge clk);
        chk("done_count", done_cnt - d0, ops);
        chk("drained", exp_res_q.size() + res_q.size() + in_q.size(), 0);
    endtask

    task automatic run_op(input bit directed);
        int d0;
        d0 = done_cnt;
        push_op(directed);
        pulse_go();
        wait_sig(2, 600);
        settle_check(d0, 1);
    endtask

    initial begin
        int d0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rstn = 1'b1;

        // directed vectors; the pass instance covers the RELU=0 expectation
        run_op(1);

        // random input gaps, 10-cycle output stall
        rand_in = 1; stall_out = 1;
        run_op(1);
        rand_in = 0; stall_out = 0;

        // go while busy is ignored; go during the all_done pulse starts a new operation
        d0 = done_cnt;
        push_op(0);
        pulse_go();
        wait_sig(0, 200);
        repeat (2) @(negedge clk);
        go = 1'b1;
        @(negedge clk); go = 1'b0;
        wait_sig(1, 200);
        go = 1'b1;
        @(negedge clk); go = 1'b0;
        push_op(0);
        wait_sig(2, 400);
        go = 1'b1;
        @(negedge clk); go = 1'b0;
        wait_sig(2, 400);
        settle_check(d0, 2);

        // reset during WAIT of row0, then a fresh directed run
        long_lat = 1;
        push_op(0);
        pulse_go();
        wait_sig(0, 200);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_reset_vals();
        @(negedge clk);
        rstn = 1'b1;
        long_lat = 0;
        run_op(1);

        // dot_done left high across the next start
        stale = 1;
        run_op(0);
        run_op(1);
        stale = 0;

        for (int k = 0; k < 20; k++) begin
            rand_in  = 1'($urandom_range(0, 1));
            rand_out = 1'($urandom_range(0, 1));
            stale    = 1'($urandom_range(0, 1));
            run_op(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

endmodule
